// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller for a word-only data memory.
// Sub-word and unaligned accesses become a fixed READ -> COMMIT sequence.
// Loads are extracted and extended from the word read back; stores merge
// into that word and write it back.
module mem_access_unit #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [3:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   rt_old,
  output logic          busy,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_COMMIT} state_e;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,  OP_LB  = 4'd1,  OP_LBU = 4'd2,  OP_LH  = 4'd3,
    OP_LHU = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6,  OP_SW  = 4'd8,
    OP_SB  = 4'd9,  OP_SH  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12
  } op_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q, rt_old_q, buf_q;
  logic           done_q, err_q;
  logic [31:0]    rdata_q;

  logic [1:0]     n;
  logic           is_store, err_d;
  logic [31:0]    ld_word, st_word, rdata_d;
  logic           done_d;
  logic [3:0][7:0] bb, wb, ldb, stb;

  // Address bits above the memory window are ignored (accesses wrap at 4 KiB).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign n = addr_q[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed three-cycle walk IDLE -> READ -> COMMIT -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = S_READ;
      S_READ:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall flag, memory address and write strobe.
  always_comb begin
    busy     = (state_q != S_IDLE);
    mem_addr = (state_q == S_IDLE) ? '0 : addr_q[AW+1:2];
    mem_we   = (state_q == S_COMMIT) && is_store && !err_d && !reset;
    mem_din  = st_word;
  end

  // Op decode: store class and alignment / validity errors.
  always_comb begin
    is_store = 1'b0;
    err_d    = 1'b0;
    case (op_q)
      OP_LW:                      err_d = (n != 2'd0);
      OP_SW:              begin   err_d = (n != 2'd0); is_store = 1'b1; end
      OP_LH, OP_LHU:              err_d = addr_q[0];
      OP_SH:              begin   err_d = addr_q[0];   is_store = 1'b1; end
      OP_LB, OP_LBU, OP_LWL, OP_LWR: err_d = 1'b0;
      OP_SB, OP_SWL, OP_SWR:      is_store = 1'b1;
      default:                    err_d = 1'b1;
    endcase
  end

  // Byte lanes: load extraction/merge and store merge into the buffered word.
  always_comb begin
    bb  = buf_q;
    wb  = wdata_q;
    ldb = '0;
    stb = buf_q;
    case (op_q)
      OP_LW:  ldb = buf_q;
      OP_LB:  ldb = {{24{bb[n][7]}}, bb[n]};
      OP_LBU: ldb = {24'd0, bb[n]};
      OP_LH:  ldb = {{16{bb[{n[1], 1'b1}][7]}}, bb[{n[1], 1'b1}], bb[{n[1], 1'b0}]};
      OP_LHU: ldb = {16'd0, bb[{n[1], 1'b1}], bb[{n[1], 1'b0}]};
      OP_LWL: begin
        ldb = rt_old_q;
        for (int unsigned j = 0; j < 4; j++)
          if (2'(j) <= n) ldb[2'd3 - n + 2'(j)] = bb[2'(j)];
      end
      OP_LWR: begin
        ldb = rt_old_q;
        for (int unsigned j = 0; j < 4; j++)
          if (2'(j) >= n) ldb[2'(j) - n] = bb[2'(j)];
      end
      OP_SW:  stb = wdata_q;
      OP_SB:  stb[n] = wb[0];
      OP_SH: begin
        stb[{n[1], 1'b0}] = wb[0];
        stb[{n[1], 1'b1}] = wb[1];
      end
      OP_SWL:
        for (int unsigned j = 0; j < 4; j++)
          if (2'(j) <= n) stb[2'(j)] = wb[2'd3 - n + 2'(j)];
      OP_SWR:
        for (int unsigned j = 0; j < 4; j++)
          if (2'(j) >= n) stb[2'(j)] = wb[2'(j) - n];
      default: ldb = '0;
    endcase
    ld_word = ldb;
    st_word = stb;
  end

  assign rdata_d = (is_store || err_d) ? '0 : ld_word;
  assign done_d  = (state_q == S_COMMIT);

  // Request latches and read buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rt_old_q <= '0;
      buf_q    <= '0;
    end else begin
      if (state_q == S_IDLE && req) begin
        op_q     <= op;
        addr_q   <= addr[AW+1:0];
        wdata_q  <= wdata;
        rt_old_q <= rt_old;
      end
      if (state_q == S_READ) buf_q <= mem_dout;
    end
  end

  // Completion pulse and result registers, loaded on the COMMIT edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= done_d;
      if (state_q == S_COMMIT) begin
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end
  end

  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller that sits between the MEM pipeline stage and the word-only data memory.
- The data memory it drives has a 10-bit word address (byte address bits [11:2]), a combinational read, and a synchronous write on the rising clock edge with write enable.
- This block converts byte, halfword, unaligned-left and unaligned-right loads and stores into whole-word read-modify-write sequences, then returns aligned, extended load data.
- It raises busy while an access is in flight, so the pipeline stalls for the duration.

Parameters:
- AW, 10: memory word-address width; mem_addr = addr[AW+1:2].

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only while idle.
- op  in  4  operation. 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 8 SW, 9 SB, 10 SH, 11 SWL, 12 SWR. All other codes are invalid.
- addr  in  32  byte address.
- wdata  in  32  store data (rt).
- rt_old  in  32  current rt value, used for the LWL/LWR merge.
- busy  out  1  high while the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid while done=1.
- err  out  1  misaligned or invalid op; valid while done=1.
- mem_addr  out  AW  word address to the memory.
- mem_din  out  32  merged write word.
- mem_we  out  1  memory write enable.
- mem_dout  in  32  combinational read data from the memory.

Behaviour:
- Reset values: state=IDLE, done=0, err=0, rdata=0, busy=0, mem_we=0. The internal latches (op, addr, wdata, rt_old, buffer) reset to 0.
- State machine, all transitions on the rising clk edge:
  - IDLE: if req=1, latch op/addr/wdata/rt_old and go to READ. Otherwise stay in IDLE.
  - READ: drive mem_addr from the latched addr, capture mem_dout into buf, go to COMMIT.
  - COMMIT: for a valid, aligned store, drive mem_we=1 and mem_din=merge(buf, wdata). Go to IDLE. On that edge load done=1, err, and rdata (loads only; rdata=0 for stores and for errors).
- Timing:
  - done is high for exactly the one cycle after the COMMIT edge.
  - Request accepted at edge N gives memory write at edge N+2 and done high during cycle N+2..N+3.
  - Fixed 3-cycle latency for every op, including error cases.
- busy = (state != IDLE), decoded combinationally.
- req is ignored while busy. A new req may be accepted in the same cycle that done=1.
- mem_addr is driven from the latched addr in READ and COMMIT, and is 0 in IDLE.
- mem_we = (state==COMMIT) & store op & ~err & ~reset. Asserting reset during COMMIT therefore suppresses the write.
- Byte ordering is little-endian: byte k of a word occupies bits [8k+7:8k]. n = addr[1:0].
- Error conditions (memory is not written and rdata=0 when err=1):
  - LW/SW with n != 0.
  - LH/LHU/SH with addr[0]=1.
  - Any invalid op code.
- Load results:
  - LB/LBU: memory byte n, sign-extended or zero-extended.
  - LH/LHU: memory halfword at bytes n..n+1, sign-extended or zero-extended.
  - LWL: rt_old bytes 3-n..3 are replaced by memory bytes 0..n.
  - LWR: rt_old bytes 0..3-n are replaced by memory bytes n..3.
- Store merges (bytes not listed keep their buf value):
  - SB: byte n = wdata[7:0].
  - SH: bytes n..n+1 = wdata[15:0].
  - SWL: memory byte j = wdata byte (3-n+j), for j <= n.
  - SWR: memory byte j = wdata byte (j-n), for j >= n.
- Address bits above AW+1 are ignored, so addresses wrap modulo 4 KiB.
- Reset at any point returns the block to IDLE within one edge. done stays 0 and no write is issued.

Test Plan:
- SW 0x8899AABB at addr 0x10, then LW 0x10 → rdata=0x8899AABB, err=0. done rises exactly 2 edges after req is accepted; busy is high for 2 cycles.
- On word 0x8899AABB:
  - LB 0x10 → 0xFFFFFFBB.
  - LBU 0x10 → 0x000000BB.
  - LH 0x12 → 0xFFFF8899.
  - LHU 0x12 → 0x00008899.
- SB addr 0x11, wdata 0x000000CC → word at 0x10 becomes 0x8899CCBB. SH addr 0x12, wdata 0x1234 → word becomes 0x1234CCBB.
- On a zeroed word 0x20, with wdata 0xA1B2C3D4: SWL addr 0x21 → 0x0000A1B2, then SWR addr 0x22 → 0xC3D4A1B2. On word 0x8899CCBB with rt_old 0x01020304: LWL addr 0x10 → 0xBB020304, and LWR addr 0x13 → 0x01020388.
- Error cases:
  - LW 0x12 → err=1, rdata=0.
  - SH 0x11 → err=1 and the memory word is unchanged.
  - op=7 → err=1, no mem_we.
- Reset and overlap:
  - Assert reset during the COMMIT cycle of SW 0xDEADBEEF → mem_we stays 0, memory is unchanged, done=0, state=IDLE.
  - Hold req high continuously → back-to-back accesses are accepted every 3 cycles, and req pulses while busy are ignored.
